aplic_latency_counter_bank: RTL and testbench
=============================================

Name: aplic_latency_counter_bank

Overview:
- Bank of NR_CH independent start/stop latency counters for APLIC performance and debug instrumentation.
- Each channel measures the cycle distance between a rising edge on start_i[c] and a later rising edge on stop_i[c], and latches the result.
- Counter width and overflow policy are parametrised, with an optional per-channel maximum-latency tracker.
- Sits beside the APLIC domain logic; driven by event strobes (e.g. pending set -> claim), read by the register interface.

Parameters:
- NR_CH, 4, number of independent channels (>=1).
- CNT_W, 32, counter/result width in bits (2..64).
- SATURATE, 1, 1: counter sticks at all-ones on overflow; 0: counter wraps to 0.

Ports:
- clk_i  in  1  module clock.
- rst_sys_ni  in  1  asynchronous, active-low system reset.
- en_i  in  1  global count enable; low freezes all counters, state transitions still occur.
- start_i  in  NR_CH  per-channel start event level; rising edge arms the channel.
- stop_i  in  NR_CH  per-channel stop event level; rising edge ends the measurement.
- clr_i  in  NR_CH  per-channel synchronous clear.
- busy_o  out  NR_CH  channel in RUN.
- count_o  out  NR_CH*CNT_W  live counter; channel c occupies bits [c*CNT_W +: CNT_W].
- result_o  out  NR_CH*CNT_W  latched measurement, same packing.
- result_valid_o  out  NR_CH  result_o slice holds a completed measurement.
- ovf_o  out  NR_CH  sticky overflow of the current/last measurement.
- max_o  out  NR_CH*CNT_W  maximum result since clear (optional feature).

Behaviour:
- Reset (rst_sys_ni low): all channels IDLE; edge-history registers, count, result, result_valid, ovf, max all 0.
- Edge detection: registered per-input history. Edge = input & ~history in the same cycle, so there are no extra latency cycles.
- Per-channel FSM with states IDLE, RUN, DONE.
- IDLE: start edge -> RUN, count <= 0, ovf <= 0. A stop edge is ignored, including one in the same cycle as the start edge (start wins).
- RUN, each cycle: if en_i, count <= count + 1.
- RUN, on stop edge: result <= value count takes this cycle; result_valid <= 1; state -> DONE; count frozen.
- Resulting measurement: start edge at cycle t, stop edge at t+N, en_i high throughout -> result = N.
- RUN: start edges are ignored (no restart).
- DONE: count, result and result_valid hold.
- DONE, on start edge: -> RUN, count <= 0, ovf <= 0, result_valid <= 0; result_o keeps the old value until the next stop.
- DONE: stop edges are ignored.
- Overflow, SATURATE=1: increment from all-ones keeps all-ones and sets ovf.
- Overflow, SATURATE=0: increment from all-ones wraps to 0 and sets ovf.
- ovf is sticky until the next start edge or clr.
- clr_i[c] has highest priority over every event in that channel:
  - state -> IDLE; count, result, result_valid, ovf, max <= 0;
  - edge history <= current input level, so a level held high through clear does not retrigger.
- Channels are fully independent; no cross-channel interaction.
- All outputs are registered.

Optional Feature:
- Macro: APLIC_CNT_MAX_EN.
- Defined: per channel, on each RUN->DONE transition, max <= result if result > max. Cleared by clr_i and reset. Driven on max_o.
- Undefined: no max registers; max_o tied to 0; port list unchanged.

Test Plan:
- NR_CH=4, CNT_W=32: ch0 start edge at cycle 10, stop edge at cycle 17 -> result_o[0]=7, result_valid_o[0]=1 at cycle 18, busy_o[0] high cycles 11..17; other channels stay 0.
- ch1 start and stop rise in the same cycle -> RUN, busy_o[1]=1; stop held high (no new edge) -> stays RUN; stop falls then rises 5 cycles after start -> result=5.
- CNT_W=4, SATURATE=1: run 20 cycles -> count and result 15, ovf_o=1. SATURATE=0, same stimulus -> result=4, ovf_o=1.
- en_i low for 3 of 10 cycles between start (cycle 0) and stop (cycle 10) -> result=7. clr_i during RUN with start still high -> IDLE, all 0, no retrigger.
- rst_sys_ni asserted mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; after release, channel IDLE until a fresh start edge.
- APLIC_CNT_MAX_EN defined: measurements 9, 4, 12 -> max_o=9, 9, 12; clr_i -> 0. Undefined: max_o=0 throughout.

Source files
------------

// File: rtl/aplic_latency_counter_bank.sv
// ============================================================================
// Module   : aplic_latency_counter_bank
// Brief    : Bank of independent start/stop latency counters for APLIC
//            instrumentation. Macro APLIC_CNT_MAX_EN adds per-channel max.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aplic_latency_counter_bank #(
   parameter int unsigned NR_CH    = 4,
   parameter int unsigned CNT_W    = 32,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_sys_ni,
   input  logic                   en_i,
   input  logic [NR_CH-1:0]       start_i,
   input  logic [NR_CH-1:0]       stop_i,
   input  logic [NR_CH-1:0]       clr_i,
   output logic [NR_CH-1:0]       busy_o,
   output logic [NR_CH*CNT_W-1:0] count_o,
   output logic [NR_CH*CNT_W-1:0] result_o,
   output logic [NR_CH-1:0]       result_valid_o,
   output logic [NR_CH-1:0]       ovf_o,
   output logic [NR_CH*CNT_W-1:0] max_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   logic [NR_CH-1:0] r_start_hist;
   logic [NR_CH-1:0] r_stop_hist;
   logic [NR_CH-1:0] w_start_edge;
   logic [NR_CH-1:0] w_stop_edge;

   assign w_start_edge = start_i & ~r_start_hist;
   assign w_stop_edge  = stop_i  & ~r_stop_hist;

   // History always tracks the input level, which also covers the clear case.
   always_ff @(posedge clk_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         r_start_hist <= '0;
         r_stop_hist  <= '0;
      end else begin
         r_start_hist <= start_i;
         r_stop_hist  <= stop_i;
      end
   end

   generate
      for (genvar c = 0; c < NR_CH; c++) begin : g_ch
         state_e           r_state;
         logic             r_busy;
         logic             r_valid;
         logic             r_ovf;
         logic [CNT_W-1:0] r_count;
         logic [CNT_W-1:0] r_result;
         logic [CNT_W-1:0] w_count_nxt;
         logic             w_ovf_nxt;

         always_comb begin
            w_count_nxt = r_count;
            w_ovf_nxt   = r_ovf;
            if (en_i) begin
               if (r_count == C_CNT_MAX) begin
                  w_ovf_nxt = 1'b1;
                  if (SATURATE) begin
                     w_count_nxt = C_CNT_MAX;
                  end else begin
                     w_count_nxt = '0;
                  end
               end else begin
                  w_count_nxt = r_count + C_CNT_ONE;
               end
            end
         end

         always_ff @(posedge clk_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_valid  <= 1'b0;
               r_ovf    <= 1'b0;
               r_count  <= '0;
               r_result <= '0;
            end else if (clr_i[c]) begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_valid  <= 1'b0;
               r_ovf    <= 1'b0;
               r_count  <= '0;
               r_result <= '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (w_start_edge[c]) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                     end
                  end
                  ST_RUN: begin
                     r_count <= w_count_nxt;
                     r_ovf   <= w_ovf_nxt;
                     // The latched result includes this cycle's increment.
                     if (w_stop_edge[c]) begin
                        r_result <= w_count_nxt;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                     end
                  end
                  ST_DONE: begin
                     if (w_start_edge[c]) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end

`ifdef APLIC_CNT_MAX_EN
         logic [CNT_W-1:0] r_max;
         logic             w_done;

         assign w_done = (r_state == ST_RUN) && w_stop_edge[c];

         always_ff @(posedge clk_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
               r_max <= '0;
            end else if (clr_i[c]) begin
               r_max <= '0;
            end else if (w_done && (w_count_nxt > r_max)) begin
               r_max <= w_count_nxt;
            end
         end

         assign max_o[c*CNT_W +: CNT_W] = r_max;
`else
         assign max_o[c*CNT_W +: CNT_W] = '0;
`endif

         assign busy_o[c]                  = r_busy;
         assign result_valid_o[c]          = r_valid;
         assign ovf_o[c]                   = r_ovf;
         assign count_o[c*CNT_W +: CNT_W]  = r_count;
         assign result_o[c*CNT_W +: CNT_W] = r_result;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_aplic_latency_counter_bank.sv
// ============================================================================
// Module   : tb_aplic_latency_counter_bank
// Brief    : Scoreboard bench for aplic_latency_counter_bank (main 4x32 bank
//            plus 1x4 saturating and wrapping instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aplic_latency_counter_bank;

   logic         clk_i;
   logic         rst_sys_ni;
   logic         en_i;
   logic [3:0]   start_i, stop_i, clr_i;
   logic [3:0]   busy_o, result_valid_o, ovf_o;
   logic [127:0] count_o, result_o, max_o;

   logic         s_start, s_stop, s_clr;
   logic         busy_s, valid_s, ovf_s, busy_w, valid_w, ovf_w;
   logic [3:0]   count_s, result_s, max_s, count_w, result_w, max_w;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          ch;
      logic [31:0] res;
      logic        ovf;
      logic [31:0] mx;
   } exp_t;

   exp_t q_main[$];
   exp_t q_sat[$];
   exp_t q_wrap[$];

   aplic_latency_counter_bank #(.NR_CH(4), .CNT_W(32), .SATURATE(1'b1)) u_dut (
      .clk_i(clk_i), .rst_sys_ni(rst_sys_ni), .en_i(en_i),
      .start_i(start_i), .stop_i(stop_i), .clr_i(clr_i),
      .busy_o(busy_o), .count_o(count_o), .result_o(result_o),
      .result_valid_o(result_valid_o), .ovf_o(ovf_o), .max_o(max_o)
   );

   aplic_latency_counter_bank #(.NR_CH(1), .CNT_W(4), .SATURATE(1'b1)) u_sat (
      .clk_i(clk_i), .rst_sys_ni(rst_sys_ni), .en_i(en_i),
      .start_i(s_start), .stop_i(s_stop), .clr_i(s_clr),
      .busy_o(busy_s), .count_o(count_s), .result_o(result_s),
      .result_valid_o(valid_s), .ovf_o(ovf_s), .max_o(max_s)
   );

   aplic_latency_counter_bank #(.NR_CH(1), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
      .clk_i(clk_i), .rst_sys_ni(rst_sys_ni), .en_i(en_i),
      .start_i(s_start), .stop_i(s_stop), .clr_i(s_clr),
      .busy_o(busy_w), .count_o(count_w), .result_o(result_w),
      .result_valid_o(valid_w), .ovf_o(ovf_w), .max_o(max_w)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [31:0] mx(input logic [31:0] v);
`ifdef APLIC_CNT_MAX_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] sl(input logic [127:0] bus, input int c);
      return bus[c*32 +: 32];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push_main(input int ch, input logic [31:0] res, input logic [31:0] m);
      exp_t e;
      e.ch = ch; e.res = res; e.ovf = 1'b0; e.mx = m;
      q_main.push_back(e);
   endtask

   // One full measurement of n cycles on channel ch, expecting max m afterwards.
   task automatic measure(input int ch, input int n, input logic [31:0] m);
      start_i[ch] = 1'b1;
      cyc(1);
      cyc(n - 1);
      stop_i[ch] = 1'b1;
      push_main(ch, n, m);
      cyc(1);
      start_i[ch] = 1'b0;
      stop_i[ch]  = 1'b0;
      cyc(1);
   endtask

   // Monitor: pops expectations whenever a result_valid rises.
   logic [3:0] prev_v = 4'b0;
   logic       prev_s = 1'b0;
   logic       prev_w = 1'b0;

   always @(negedge clk_i) begin
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         if (result_valid_o[c] && !prev_v[c]) begin
            if (q_main.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL main_unexpected: got result on ch%0d, expected none", c);
            end else begin
               e = q_main.pop_front();
               check("main_ch", c, e.ch);
               check("main_result", sl(result_o, c), e.res);
               check("main_ovf", ovf_o[c], e.ovf);
               check("main_max", sl(max_o, c), e.mx);
            end
         end
      end
      if (valid_s && !prev_s) begin
         if (q_sat.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sat_unexpected: got result, expected none");
         end else begin
            e = q_sat.pop_front();
            check("sat_result", result_s, e.res);
            check("sat_ovf", ovf_s, e.ovf);
            check("sat_max", max_s, e.mx);
         end
      end
      if (valid_w && !prev_w) begin
         if (q_wrap.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL wrap_unexpected: got result, expected none");
         end else begin
            e = q_wrap.pop_front();
            check("wrap_result", result_w, e.res);
            check("wrap_ovf", ovf_w, e.ovf);
            check("wrap_max", max_w, e.mx);
         end
      end
      prev_v = result_valid_o;
      prev_s = valid_s;
      prev_w = valid_w;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst_sys_ni = 1'b0;
      en_i       = 1'b1;
      start_i    = '0;
      stop_i     = '0;
      clr_i      = '0;
      s_start    = 1'b0;
      s_stop     = 1'b0;
      s_clr      = 1'b0;
      cyc(2);

      // Reset state
      check("rst_busy", busy_o, 0);
      check("rst_count", count_o, 0);
      check("rst_result", result_o, 0);
      check("rst_valid", result_valid_o, 0);
      check("rst_ovf", ovf_o, 0);
      check("rst_max", max_o, 0);
      check("rst_sat_count", count_s, 0);
      rst_sys_ni = 1'b1;
      cyc(2);

      // ch0: 7-cycle measurement
      start_i[0] = 1'b1;
      cyc(1);
      check("ch0_busy_start", busy_o, 4'b0001);
      check("ch0_count_start", sl(count_o, 0), 0);
      cyc(6);
      check("ch0_count_run", sl(count_o, 0), 6);
      check("ch0_busy_run", busy_o, 4'b0001);
      stop_i[0] = 1'b1;
      push_main(0, 7, mx(7));
      cyc(1);
      check("ch0_busy_done", busy_o, 4'b0000);
      check("ch0_valid", result_valid_o, 4'b0001);
      check("ch0_result", sl(result_o, 0), 7);
      cyc(2);
      check("ch0_count_hold", sl(count_o, 0), 7);
      start_i[0] = 1'b0;
      stop_i[0]  = 1'b0;
      cyc(1);

      // ch1: start and stop rise together, start wins
      start_i[1] = 1'b1;
      stop_i[1]  = 1'b1;
      cyc(1);
      check("ch1_busy_sim", busy_o[1], 1'b1);
      cyc(2);
      check("ch1_busy_held", busy_o[1], 1'b1);
      stop_i[1] = 1'b0;
      cyc(2);
      stop_i[1] = 1'b1;
      push_main(1, 5, mx(5));
      cyc(1);
      check("ch1_result", sl(result_o, 1), 5);
      start_i[1] = 1'b0;
      stop_i[1]  = 1'b0;
      cyc(1);

      // ch3: en_i low for 3 of 10 cycles
      start_i[3] = 1'b1;
      cyc(1);
      en_i = 1'b0;
      cyc(3);
      check("ch3_count_frozen", sl(count_o, 3), 0);
      en_i = 1'b1;
      cyc(6);
      stop_i[3] = 1'b1;
      push_main(3, 7, mx(7));
      cyc(1);
      stop_i[3] = 1'b0;

      // ch3: clear mid-run with start held high
      start_i[3] = 1'b0;
      cyc(1);
      start_i[3] = 1'b1;
      cyc(3);
      check("ch3_busy_rerun", busy_o[3], 1'b1);
      check("ch3_valid_rerun", result_valid_o[3], 1'b0);
      clr_i[3] = 1'b1;
      cyc(1);
      clr_i[3] = 1'b0;
      check("clr_busy", busy_o[3], 1'b0);
      check("clr_count", sl(count_o, 3), 0);
      check("clr_result", sl(result_o, 3), 0);
      check("clr_valid", result_valid_o[3], 1'b0);
      check("clr_ovf", ovf_o[3], 1'b0);
      check("clr_max", sl(max_o, 3), 0);
      cyc(3);
      check("clr_no_retrigger", busy_o[3], 1'b0);
      start_i[3] = 1'b0;
      cyc(1);

      // ch2: max tracking over 9, 4, 12
      measure(2, 9, mx(9));
      measure(2, 4, mx(9));
      measure(2, 12, mx(12));
      check("ch2_max_final", sl(max_o, 2), mx(12));
      clr_i[2] = 1'b1;
      cyc(1);
      clr_i[2] = 1'b0;
      check("ch2_max_clr", sl(max_o, 2), 0);
      check("ch2_result_clr", sl(result_o, 2), 0);

      // 4-bit saturate / wrap over a 20-cycle measurement
      s_start = 1'b1;
      cyc(1);
      cyc(15);
      check("sat_count_15", count_s, 15);
      check("sat_ovf_pre", ovf_s, 1'b0);
      cyc(1);
      check("sat_count_stick", count_s, 15);
      check("sat_ovf_set", ovf_s, 1'b1);
      check("wrap_count_zero", count_w, 0);
      check("wrap_ovf_set", ovf_w, 1'b1);
      cyc(3);
      s_stop = 1'b1;
      e.ch = 0; e.res = 15; e.ovf = 1'b1; e.mx = mx(15);
      q_sat.push_back(e);
      e.res = 4; e.mx = mx(4);
      q_wrap.push_back(e);
      cyc(1);
      check("wrap_count_end", count_w, 4);
      s_start = 1'b0;
      s_stop  = 1'b0;
      cyc(1);

      // Asynchronous reset mid-run on ch0
      start_i[0] = 1'b1;
      cyc(3);
      check("arst_busy_pre", busy_o[0], 1'b1);
      #2;
      rst_sys_ni = 1'b0;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_count", count_o, 0);
      check("arst_result", result_o, 0);
      check("arst_valid", result_valid_o, 0);
      check("arst_ovf", ovf_o, 0);
      check("arst_max", max_o, 0);
      start_i[0] = 1'b0;
      cyc(1);
      rst_sys_ni = 1'b1;
      cyc(3);
      check("arst_idle", busy_o, 0);
      start_i[0] = 1'b1;
      cyc(1);
      check("arst_fresh_start", busy_o, 4'b0001);
      cyc(2);
      stop_i[0] = 1'b1;
      push_main(0, 3, mx(3));
      cyc(1);
      start_i[0] = 1'b0;
      stop_i[0]  = 1'b0;
      cyc(3);

      check("q_main_empty", q_main.size(), 0);
      check("q_sat_empty", q_sat.size(), 0);
      check("q_wrap_empty", q_wrap.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
